// File: rtl/pe_tile_scheduler_if.sv
// pe_tile_scheduler_if: job descriptor, PE config bus and status signals of the tile scheduler
interface pe_tile_scheduler_if #(
  parameter int TILE_CNT_W = 8,
  parameter int TIMEOUT_W = 20
);
  logic job_valid;
  logic job_ready;
  logic [TILE_CNT_W-1:0] job_num_tiles;
  logic [31:0] job_geom_kernel;
  logic [31:0] job_geom_input;
  logic [31:0] job_geom_conv;
  logic [31:0] job_geom_output;
  logic [TIMEOUT_W-1:0] job_timeout;
  logic abort;
  logic cfg_we;
  logic [3:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic busy;
  logic [TILE_CNT_W-1:0] tile_idx;
  logic tile_done;
  logic job_done;
  logic job_err;
  modport master (
    input job_valid, job_num_tiles, job_geom_kernel, job_geom_input, job_geom_conv,
          job_geom_output, job_timeout, abort, cfg_rdata,
    output job_ready, cfg_we, cfg_addr, cfg_wdata, busy, tile_idx, tile_done, job_done, job_err
  );
  modport slave (
    output job_valid, job_num_tiles, job_geom_kernel, job_geom_input, job_geom_conv,
           job_geom_output, job_timeout, abort, cfg_rdata,
    input job_ready, cfg_we, cfg_addr, cfg_wdata, busy, tile_idx, tile_done, job_done, job_err
  );
endinterface

// File: rtl/pe_tile_scheduler.sv
// pe_tile_scheduler: sequences a multi-tile convolution job over the PE config bus
module pe_tile_scheduler #(
  parameter int TILE_CNT_W = 8,
  parameter int TIMEOUT_W = 20,
  parameter int POLL_GAP = 4
) (
  input logic clk,
  input logic rst_n,
  pe_tile_scheduler_if.master bus
);
  localparam int CW = $clog2(POLL_GAP + 1) > 2 ? $clog2(POLL_GAP + 1) : 2;
  typedef enum logic [2:0] {IDLE, CFG, START, POLL, TILE_END, FINISH} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TIMEOUT_W-1:0] tcnt, tcnt_n, tmo, tmo_n;
  logic [TILE_CNT_W-1:0] num, num_n, tile_n;
  logic [3:0][31:0] geom, geom_n;
  logic abort_seen, abort_n, err_n, accept, we_n;
  logic [3:0] addr_n;
  logic [31:0] wdata_n;
  logic unused_rdata;
  assign unused_rdata = ^bus.cfg_rdata[31:1];
  assign accept = bus.job_valid && bus.job_ready;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    tcnt_n = tcnt;
    tmo_n = tmo;
    num_n = num;
    geom_n = geom;
    tile_n = bus.tile_idx;
    err_n = bus.job_err;
    abort_n = abort_seen || (bus.abort && state != IDLE && state != FINISH);
    case (state)
      IDLE, FINISH: begin
        state_n = IDLE;
        if (accept) begin
          num_n = bus.job_num_tiles;
          geom_n = {bus.job_geom_output, bus.job_geom_conv, bus.job_geom_input, bus.job_geom_kernel};
          tmo_n = bus.job_timeout;
          err_n = 1'b0;
          abort_n = 1'b0;
          tile_n = '0;
          cnt_n = '0;
          state_n = bus.job_num_tiles == '0 ? FINISH : CFG;
        end
      end
      CFG: begin
        cnt_n = cnt == CW'(3) ? '0 : cnt + 1'b1;
        state_n = cnt == CW'(3) ? START : CFG;
      end
      START: begin
        cnt_n = cnt[0] ? '0 : cnt + 1'b1;
        state_n = cnt[0] ? POLL : START;
        tcnt_n = cnt[0] ? tmo : tcnt;
      end
      POLL: begin
        cnt_n = cnt == CW'(POLL_GAP) ? '0 : cnt + 1'b1;
        tcnt_n = tcnt - 1'b1;
        // status is sampled on the second cycle of each window; done beats a coincident timeout
        if (cnt == CW'(1) && bus.cfg_rdata[0]) state_n = TILE_END;
        else if (tmo != '0 && tcnt == TIMEOUT_W'(1)) begin
          state_n = FINISH;
          err_n = 1'b1;
        end
      end
      TILE_END: begin
        abort_n = 1'b0;
        cnt_n = '0;
        if (abort_seen || bus.abort || bus.tile_idx == num - 1'b1) state_n = FINISH;
        else begin
          state_n = START;
          tile_n = bus.tile_idx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    we_n = state_n == CFG || state_n == START;
    addr_n = state_n == CFG ? 4'(cnt_n) + 4'h2 : state_n == POLL ? 4'h1 : 4'h0;
    wdata_n = state_n == CFG ? geom_n[cnt_n[1:0]] : (state_n == START && cnt_n == '0) ? 32'd1 : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      tcnt <= '0;
      tmo <= '0;
      num <= '0;
      geom <= '0;
      abort_seen <= 1'b0;
      bus.job_ready <= 1'b1;
      bus.busy <= 1'b0;
      bus.cfg_we <= 1'b0;
      bus.cfg_addr <= '0;
      bus.cfg_wdata <= '0;
      bus.tile_idx <= '0;
      bus.tile_done <= 1'b0;
      bus.job_done <= 1'b0;
      bus.job_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      tcnt <= tcnt_n;
      tmo <= tmo_n;
      num <= num_n;
      geom <= geom_n;
      abort_seen <= abort_n;
      bus.job_ready <= state_n == IDLE || state_n == FINISH;
      bus.busy <= !(state_n == IDLE || state_n == FINISH);
      bus.cfg_we <= we_n;
      bus.cfg_addr <= addr_n;
      bus.cfg_wdata <= wdata_n;
      bus.tile_idx <= tile_n;
      bus.tile_done <= state_n == TILE_END;
      bus.job_done <= state_n == FINISH;
      bus.job_err <= err_n;
    end
  end
endmodule

// File: tb/tb_pe_tile_scheduler.sv
// tb_pe_tile_scheduler: randomized jobs against a PE status stub, checked with a job-level model
module tb_pe_tile_scheduler;
  localparam int TW = 8;
  localparam int OW = 20;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int jd_n, jd_cyc, td_cyc, st_cyc, acc_cyc;
  int lat = 0;
  int dcnt = 0;
  logic done_q = 1'b0;
  logic [35:0] wr_q[$];
  int td_q[$];

  pe_tile_scheduler_if #(.TILE_CNT_W(TW), .TIMEOUT_W(OW)) ifc ();
  pe_tile_scheduler #(.TILE_CNT_W(TW), .TIMEOUT_W(OW), .POLL_GAP(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );

  always #5 clk = ~clk;

  // PE stub: start clears done, which then rises lat cycles later (lat 0 = never)
  always @(posedge clk) begin
    ifc.cfg_rdata <= (ifc.cfg_addr == 4'h1) ? {31'b0, done_q} : 32'h0;
    if (ifc.cfg_we && ifc.cfg_addr == 4'h0 && ifc.cfg_wdata[0]) begin
      done_q <= 1'b0;
      dcnt <= lat;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) done_q <= 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (ifc.cfg_we) begin
      wr_q.push_back({ifc.cfg_addr, ifc.cfg_wdata});
      if (ifc.cfg_addr == 4'h0 && ifc.cfg_wdata == 32'd1 && st_cyc < 0) st_cyc = cyc;
    end
    if (ifc.tile_done) begin
      td_q.push_back(int'(ifc.tile_idx));
      td_cyc = cyc;
    end
    if (ifc.job_done) begin
      jd_n++;
      jd_cyc = cyc;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_job(input string name, input int n, input logic [31:0] k, gi, gc, go,
                          input int tmo, input int dlat, input int ab);
    logic [35:0] exp_q[$];
    int att, ndone;
    bit hit, ab_sent;
    hit = n > 0 && tmo != 0 && (dlat == 0 || dlat >= 2 * tmo);
    att = hit ? 1 : (ab < n ? ab + 1 : n);
    ndone = hit ? 0 : att;
    if (n > 0) exp_q = '{{4'h2, k}, {4'h3, gi}, {4'h4, gc}, {4'h5, go}};
    for (int t = 0; t < att; t++) begin
      exp_q.push_back({4'h0, 32'd1});
      exp_q.push_back({4'h0, 32'd0});
    end
    wr_q.delete();
    td_q.delete();
    jd_n = 0;
    st_cyc = -1;
    lat = dlat;
    ab_sent = 0;
    ifc.job_num_tiles = TW'(n);
    ifc.job_geom_kernel = k;
    ifc.job_geom_input = gi;
    ifc.job_geom_conv = gc;
    ifc.job_geom_output = go;
    ifc.job_timeout = OW'(tmo);
    ifc.job_valid = 1'b1;
    step();
    ifc.job_valid = 1'b0;
    acc_cyc = cyc;
    ifc.job_num_tiles = TW'($urandom);
    ifc.job_geom_kernel = $urandom;
    ifc.job_geom_input = $urandom;
    ifc.job_geom_conv = $urandom;
    ifc.job_geom_output = $urandom;
    ifc.job_timeout = OW'($urandom);
    checks++;
    if (ifc.job_err !== 1'b0) begin
      failures++;
      $display("FAIL %s err_clear_on_accept got=%b exp=0", name, ifc.job_err);
    end
    checks++;
    if (ifc.busy !== logic'(n > 0)) begin
      failures++;
      $display("FAIL %s busy_after_accept got=%b exp=%b", name, ifc.busy, n > 0);
    end
    for (int w = 0; w < 4000 && jd_n == 0; w++) begin
      ifc.abort = !ab_sent && ab < n && ifc.busy && int'(ifc.tile_idx) == ab;
      if (ifc.abort) ab_sent = 1;
      step();
    end
    ifc.abort = 1'b0;
    checks++;
    if (jd_n == 0) begin
      failures++;
      $display("FAIL %s job_done_wait got=none exp=pulse", name);
    end
    repeat (3) step();
    checks++;
    if (jd_n != 1) begin
      failures++;
      $display("FAIL %s job_done_count got=%0d exp=1", name, jd_n);
    end
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s write_count got=%0d exp=%0d", name, wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s write[%0d] got=%h exp=%h", name, i, wr_q[i], exp_q[i]);
      end
    end
    checks++;
    if (td_q.size() != ndone) begin
      failures++;
      $display("FAIL %s tile_done_count got=%0d exp=%0d", name, td_q.size(), ndone);
    end
    for (int i = 0; i < td_q.size() && i < ndone; i++) begin
      checks++;
      if (td_q[i] != i) begin
        failures++;
        $display("FAIL %s tile_done_idx[%0d] got=%0d exp=%0d", name, i, td_q[i], i);
      end
    end
    checks++;
    if (ifc.job_err !== hit || ifc.job_ready !== 1'b1 || ifc.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s end_status got=err%b/ready%b/busy%b exp=err%b/ready1/busy0",
               name, ifc.job_err, ifc.job_ready, ifc.busy, hit);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if ({ifc.job_ready, ifc.busy, ifc.cfg_we, ifc.tile_idx, ifc.job_err, ifc.job_done, ifc.tile_done}
        !== {1'b1, 1'b0, 1'b0, TW'(0), 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got=ready%b busy%b we%b idx%0d err%b jd%b td%b exp=ready1 rest0",
               ifc.job_ready, ifc.busy, ifc.cfg_we, ifc.tile_idx, ifc.job_err, ifc.job_done, ifc.tile_done);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_tile();
    test_job("single", 1, 32'h33, 32'h0808, 32'h01, 32'h0606, 1000, 20, 99);
    checks++;
    if (jd_cyc - td_cyc != 1) begin
      failures++;
      $display("FAIL single job_done_after_tile_done got=%0d exp=1", jd_cyc - td_cyc);
    end
  endtask

  task automatic test_multi_tile();
    int starts = 0;
    test_job("multi", 3, $urandom, $urandom, $urandom, $urandom, 1000, 15, 99);
    foreach (wr_q[i]) if (wr_q[i] == {4'h0, 32'd1}) starts++;
    checks++;
    if (starts != 3) begin
      failures++;
      $display("FAIL multi start_writes got=%0d exp=3", starts);
    end
  endtask

  task automatic test_zero_tiles();
    test_job("zero", 0, $urandom, $urandom, $urandom, $urandom, 1000, 20, 99);
    checks++;
    if (jd_cyc - acc_cyc < 0 || jd_cyc - acc_cyc > 2) begin
      failures++;
      $display("FAIL zero job_done_latency got=%0d exp=0..2", jd_cyc - acc_cyc);
    end
  endtask

  task automatic test_timeout();
    test_job("timeout", 2, $urandom, $urandom, $urandom, $urandom, 50, 0, 99);
    checks++;
    if (jd_cyc - st_cyc < 50 || jd_cyc - st_cyc > 55) begin
      failures++;
      $display("FAIL timeout job_done_after_start got=%0d exp=50..55", jd_cyc - st_cyc);
    end
    test_job("after_timeout", 1, $urandom, $urandom, $urandom, $urandom, 1000, 12, 99);
  endtask

  task automatic test_abort();
    test_job("abort", 5, $urandom, $urandom, $urandom, $urandom, 0, 15, 1);
  endtask

  task automatic test_reset_mid_poll();
    lat = 500;
    ifc.job_num_tiles = TW'(2);
    ifc.job_timeout = '0;
    ifc.job_valid = 1'b1;
    step();
    ifc.job_valid = 1'b0;
    for (int w = 0; w < 100 && ifc.cfg_addr !== 4'h1; w++) step();
    checks++;
    if (ifc.cfg_addr !== 4'h1) begin
      failures++;
      $display("FAIL rst_poll reach_poll got=addr%0h exp=addr1", ifc.cfg_addr);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({ifc.job_ready, ifc.busy, ifc.cfg_we, ifc.cfg_addr, ifc.cfg_wdata, ifc.tile_idx,
         ifc.tile_done, ifc.job_done, ifc.job_err}
        !== {1'b1, 1'b0, 1'b0, 4'h0, 32'h0, TW'(0), 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_poll outputs got=ready%b busy%b we%b addr%0h wd%h idx%0d td%b jd%b err%b exp=ready1 rest0",
               ifc.job_ready, ifc.busy, ifc.cfg_we, ifc.cfg_addr, ifc.cfg_wdata, ifc.tile_idx,
               ifc.tile_done, ifc.job_done, ifc.job_err);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    int n, tmo, ab;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 4);
      ab = $urandom_range(0, n);
      case ($urandom_range(0, 2))
        0: tmo = 0;
        1: tmo = 1000;
        default: tmo = 5;
      endcase
      test_job($sformatf("rand%0d", j), n, $urandom, $urandom, $urandom, $urandom,
               tmo, $urandom_range(10, 30), ab);
    end
  endtask

  initial begin
    ifc.job_valid = 1'b0;
    ifc.job_num_tiles = '0;
    ifc.job_geom_kernel = '0;
    ifc.job_geom_input = '0;
    ifc.job_geom_conv = '0;
    ifc.job_geom_output = '0;
    ifc.job_timeout = '0;
    ifc.abort = 1'b0;
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_zero_tiles();
    test_timeout();
    test_abort();
    test_reset_mid_poll();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/pe_tile_scheduler.md
Name: pe_tile_scheduler

Overview:
- Sequences the PE system through a multi-tile convolution job by driving its 32-bit configuration bus.
- For each tile it programs the geometry registers, pulses start, polls the status register until done, then advances to the next tile.
- Sits between the host/DMA job interface and the PE system config port, and is the only master of that bus while busy.
- Reports per-tile completion, job completion and timeout errors.

Parameters:
- TILE_CNT_W, 8, width of tile count and tile index.
- TIMEOUT_W, 20, width of the per-tile poll timeout counter.
- POLL_GAP, 4, idle cycles between status polls (minimum 1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- job_valid  input  1  job descriptor valid
- job_ready  output  1  scheduler can accept a job
- job_num_tiles  input  TILE_CNT_W  number of tiles; 0 is legal
- job_geom_kernel  input  32  value for CFG reg 0x2: kernel_h[3:0], kernel_w[7:4]
- job_geom_input  input  32  value for CFG reg 0x3: input_h[7:0], input_w[15:8]
- job_geom_conv  input  32  value for CFG reg 0x4: stride[3:0], padding[7:4]
- job_geom_output  input  32  value for CFG reg 0x5: output_h[7:0], output_w[15:8]
- job_timeout  input  TIMEOUT_W  poll cycles allowed per tile; 0 disables the timeout
- abort  input  1  cancel the job at the next tile boundary
- cfg_we  output  1  config write strobe
- cfg_addr  output  4  config address
- cfg_wdata  output  32  config write data
- cfg_rdata  input  32  config read data; valid one cycle after cfg_addr is presented
- busy  output  1  job in progress
- tile_idx  output  TILE_CNT_W  index of the current tile
- tile_done  output  1  one-cycle pulse when a tile completes
- job_done  output  1  one-cycle pulse at job end
- job_err  output  1  sticky timeout flag; cleared on the next accepted job

Behaviour:
- Register map used:
  - 0x0 CTRL: bit0 start; writing 1 clears STATUS.done.
  - 0x1 STATUS: bit0 done, sticky until the next start.
  - 0x2..0x5 geometry registers.
- Reset (rst_n low at a clock edge): state=IDLE; job_ready=1; all other outputs 0; internal counters 0.
- All outputs are registered.
- IDLE:
  - On job_valid && job_ready, latch all job_* fields, clear job_err, and set busy=1, job_ready=0.
  - If num_tiles==0, go to FINISH. Otherwise tile_idx=0 and go to CFG.
- CFG: 4 consecutive cycles with cfg_we=1 writing addresses 0x2, 0x3, 0x4, 0x5 with the latched values, then go to START.
- START: one cycle with cfg_we=1, cfg_addr=0x0, cfg_wdata=1. Then one cycle with cfg_we=1, cfg_wdata=0 (start is level in CTRL). Load the timeout counter and go to POLL.
- POLL:
  - cfg_we=0, cfg_addr=0x1 held.
  - Sample cfg_rdata[0] on the second cycle of each poll window; the window is POLL_GAP+1 cycles.
  - done=1: go to TILE_END.
  - Timeout counter reaching 0 (only if job_timeout!=0): set job_err=1 and go to FINISH.
  - The counter decrements once per cycle in POLL.
- TILE_END:
  - Pulse tile_done=1 for one cycle.
  - If abort was seen high at any point since the last tile boundary, or tile_idx==num_tiles-1, go to FINISH.
  - Otherwise increment tile_idx and go to START; geometry is not rewritten because it is unchanged within a job.
- FINISH: pulse job_done=1, busy=0, job_ready=1, then go to IDLE. tile_idx holds its last value until the next job.
- Outside START, cfg_we is 0 and cfg_wdata is 0 (except the CFG writes).
- abort:
  - In IDLE it is ignored.
  - During POLL it does not interrupt the tile; it is latched and honoured at TILE_END.
- Simultaneous done and timeout in the same sample: done wins.
- Reset asserted mid-job returns to IDLE next cycle with all outputs at reset values. No CTRL write is issued, so the PE may finish silently.
- A job_valid presented while busy is not accepted (job_ready=0); the job_* fields may change freely in that time.

Test Plan:
- Reset: rst_n low 2 cycles -> job_ready=1, busy=0, cfg_we=0, tile_idx=0, job_err=0.
- Single tile:
  - Stimulus: num_tiles=1, kernel=0x33, input=0x0808, conv=0x01, output=0x0606, timeout=1000; stub asserts done 20 cycles after start.
  - Required response: writes 0x2..0x5 in order with exact data; CTRL writes 1 then 0; one tile_done; job_done one cycle later; job_err=0.
- Multi-tile: num_tiles=3 -> exactly 3 CTRL start writes, tile_done with tile_idx 0, 1, 2, one job_done, geometry written once.
- Zero tiles: num_tiles=0 -> no cfg_we activity, job_done pulses within 2 cycles of acceptance.
- Timeout: timeout=50, done never asserted -> job_err=1 and job_done about 50 cycles after start, tile_done never pulses; next accepted job clears job_err.
- Abort and reset:
  - num_tiles=5 with abort pulsed during tile 1 -> tile_done for tiles 0 and 1 only, then job_done.
  - Separately, rst_n low during POLL -> IDLE and outputs at reset values the following cycle.
